// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard / stall controller.
//   state_e        FSM state encoding (RUN, STALL, FLUSH)
//   fwd_sel_t      EX operand mux select, with FWD_* encodings
//   tmr_t          stall timer word, with STALL_* total stall lengths
//   SC_W           width of the saturating stall-cycle counter
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_EXMEM   = 2'b01;
  localparam fwd_sel_t FWD_MEMWB   = 2'b10;

  // Stall lengths are totals in cycles, counting the detection cycle.
  localparam int TMR_W = 2;
  typedef logic [TMR_W-1:0] tmr_t;
  localparam tmr_t STALL_LOAD_USE = 2'd1;
  localparam tmr_t STALL_EX       = 2'd2;
  localparam tmr_t STALL_MEM      = 2'd1;

  localparam int SC_W = 16;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side signals of the hazard controller.
//   master modport: pipeline (drives match/valid/branch, reads controls)
//   slave  modport: hazard_stall_ctrl
// Inputs to controller : id_valid, ex_fwd, ex_src, mem_fwd, mem_src,
//                        ex_is_load, branch_taken
// Outputs of controller: pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
//                        fwd_sel_a, fwd_sel_b, stall_cycles
interface hazard_stall_ctrl_if;
  import hazard_pkg::*;

  logic            id_valid;
  logic            ex_fwd;
  logic            ex_src;
  logic            mem_fwd;
  logic            mem_src;
  logic            ex_is_load;
  logic            branch_taken;
  logic            pc_stall;
  logic            if_id_stall;
  logic            id_ex_bubble;
  logic            if_id_flush;
  fwd_sel_t        fwd_sel_a;
  fwd_sel_t        fwd_sel_b;
  logic [SC_W-1:0] stall_cycles;

  modport master (
    output id_valid, ex_fwd, ex_src, mem_fwd, mem_src, ex_is_load, branch_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
    input  fwd_sel_a, fwd_sel_b, stall_cycles
  );

  modport slave (
    input  id_valid, ex_fwd, ex_src, mem_fwd, mem_src, ex_is_load, branch_taken,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush,
    output fwd_sel_a, fwd_sel_b, stall_cycles
  );

endinterface

// File: rtl/stall_timer.sv
// stall_timer: down-counter holding the remaining stall cycles.
//   clk, rst     clock, synchronous active-high reset
//   load_i       load load_val_i (takes precedence over dec_i)
//   load_val_i   remaining stall cycles after the detection cycle
//   dec_i        decrement, stops at zero
//   clr_i        synchronous clear (highest priority after rst)
//   cnt_o        current count
//   zero_o       count is zero: no further stall
module stall_timer
  import hazard_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: decode-stage hazard detection, stall/flush control and
// registered EX operand forwarding selects.
//   clk   sole clock
//   rst   synchronous active-high reset
//   ctl   hazard_stall_ctrl_if.slave (match inputs, branch, stall/flush,
//         fwd_sel_a/b, stall_cycles)
// Build option FORWARD_EN: forwarding present, only load-use stalls (1 cycle).
// Without it: any EX match stalls 2 cycles, MEM-only match 1 cycle, and the
// forwarding selects are tied to the register file.
module hazard_stall_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  hazard_stall_ctrl_if.slave ctl
);

  state_e          state_q, state_d;
  logic            rst_q;
  logic            blk;
  logic            hazard;
  tmr_t            stall_len;
  logic            pc_stall, bubble, flush;
  logic            tmr_load, tmr_dec, tmr_clr, tmr_zero;
  tmr_t            tmr_load_val, tmr_cnt;
  logic [SC_W-1:0] sc_q, sc_d;

  // Controls stay quiet while reset is held and for one cycle after it.
  assign blk = rst | rst_q;

`ifdef FORWARD_EN
  assign hazard    = ctl.ex_fwd & ctl.ex_is_load;
  assign stall_len = STALL_LOAD_USE;
`else
  assign hazard    = ctl.ex_fwd | ctl.mem_fwd;
  assign stall_len = ctl.ex_fwd ? STALL_EX : STALL_MEM;
`endif

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= RUN;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_stall     = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    tmr_clr      = 1'b0;
    if (blk) begin
      state_d = RUN;
      tmr_clr = 1'b1;
    end else if (ctl.branch_taken) begin
      flush   = 1'b1;
      bubble  = 1'b1;
      tmr_clr = 1'b1;
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN: begin
          if (ctl.id_valid && hazard) begin
            pc_stall     = 1'b1;
            bubble       = 1'b1;
            // The detection cycle is already the first stall cycle.
            tmr_load     = 1'b1;
            tmr_load_val = stall_len - 1'b1;
            state_d      = STALL;
          end
        end
        STALL: begin
          if (!tmr_zero) begin
            pc_stall = 1'b1;
            bubble   = 1'b1;
            tmr_dec  = 1'b1;
          end
          // Leave on the last stalled cycle so no dead cycle follows it.
          if (tmr_cnt <= tmr_t'(1)) begin
            state_d = RUN;
          end
        end
        FLUSH: begin
          flush   = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  stall_timer #(.W(TMR_W)) u_stall_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .dec_i     (tmr_dec),
    .clr_i     (tmr_clr),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  assign sc_d = (pc_stall && (sc_q != '1)) ? sc_q + 1'b1 : sc_q;

`ifdef FORWARD_EN
  fwd_sel_t fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  // Per operand: EX/MEM result is newer than MEM/WB, so it wins.
  always_comb begin
    fwd_a_d = FWD_REGFILE;
    fwd_b_d = FWD_REGFILE;
    if (!bubble) begin
      if (ctl.ex_fwd && !ctl.ex_src)        fwd_a_d = FWD_EXMEM;
      else if (ctl.mem_fwd && !ctl.mem_src) fwd_a_d = FWD_MEMWB;
      if (ctl.ex_fwd && ctl.ex_src)         fwd_b_d = FWD_EXMEM;
      else if (ctl.mem_fwd && ctl.mem_src)  fwd_b_d = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ctl.fwd_sel_a = fwd_a_q;
  assign ctl.fwd_sel_b = fwd_b_q;
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ctl.ex_src, ctl.mem_src, ctl.ex_is_load};

  assign ctl.fwd_sel_a = FWD_REGFILE;
  assign ctl.fwd_sel_b = FWD_REGFILE;
`endif

  assign ctl.pc_stall     = pc_stall;
  assign ctl.if_id_stall  = pc_stall;
  assign ctl.id_ex_bubble = bubble;
  assign ctl.if_id_flush  = flush;
  assign ctl.stall_cycles = sc_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl.
// Inputs change on the falling edge; combinational controls are sampled 1 ns
// later, registered outputs reflect the preceding rising edges.
// Covers the default build and, when FORWARD_EN is defined, the forwarding build.
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_stall_ctrl_if hif ();

  hazard_stall_ctrl dut (
    .clk(clk),
    .rst(rst),
    .ctl(hif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic chk_ctl(input string tag, input int pc, input int bub, input int fl);
    chk({tag, "_pc_stall"}, int'(hif.pc_stall), pc);
    chk({tag, "_if_id_stall"}, int'(hif.if_id_stall), pc);
    chk({tag, "_bubble"}, int'(hif.id_ex_bubble), bub);
    chk({tag, "_flush"}, int'(hif.if_id_flush), fl);
  endtask

  task automatic drv(input logic r, input logic iv, input logic ef, input logic es,
                     input logic mf, input logic ms, input logic ld, input logic br);
    @(negedge clk);
    rst              = r;
    hif.id_valid     = iv;
    hif.ex_fwd       = ef;
    hif.ex_src       = es;
    hif.mem_fwd      = mf;
    hif.mem_src      = ms;
    hif.ex_is_load   = ld;
    hif.branch_taken = br;
    #1;
  endtask

  initial begin
    hif.id_valid = 1'b0; hif.ex_fwd = 1'b0; hif.ex_src = 1'b0; hif.mem_fwd = 1'b0;
    hif.mem_src = 1'b0; hif.ex_is_load = 1'b0; hif.branch_taken = 1'b0;

    // Reset held with a hazard present, then the cycle after release.
    drv(1, 1, 1, 0, 1, 0, 1, 0); chk_ctl("rst_hold", 0, 0, 0);
    drv(1, 1, 1, 0, 1, 0, 1, 0); chk_ctl("rst_hold2", 0, 0, 0);
    chk("rst_sc", int'(hif.stall_cycles), 0);
    chk("rst_fwd_a", int'(hif.fwd_sel_a), 0);
    chk("rst_fwd_b", int'(hif.fwd_sel_b), 0);
    drv(0, 1, 1, 0, 1, 0, 1, 0); chk_ctl("post_rst", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("idle", 0, 0, 0);

`ifdef FORWARD_EN
    drv(0, 1, 1, 0, 0, 0, 0, 0); chk_ctl("fwd_ex_nostall", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_ex_a", int'(hif.fwd_sel_a), 1);
    chk("fwd_ex_b", int'(hif.fwd_sel_b), 0);
    drv(0, 1, 1, 1, 1, 0, 0, 0); chk_ctl("fwd_mix_nostall", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_mix_a", int'(hif.fwd_sel_a), 2);
    chk("fwd_mix_b", int'(hif.fwd_sel_b), 1);
    drv(0, 1, 1, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_prio_a", int'(hif.fwd_sel_a), 1);
    chk("fwd_prio_b", int'(hif.fwd_sel_b), 0);
    drv(0, 1, 1, 0, 0, 0, 1, 0); chk_ctl("lu_entry", 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("lu_release", 0, 0, 0);
    chk("lu_fwd_a", int'(hif.fwd_sel_a), 0);
    chk("lu_sc", int'(hif.stall_cycles), 1);
    drv(0, 1, 1, 0, 0, 0, 1, 0); chk_ctl("br_entry", 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("br_in_stall", 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_2nd", 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_done", 0, 0, 0);
    chk("br_sc", int'(hif.stall_cycles), 2);
`else
    drv(0, 1, 1, 0, 1, 0, 0, 0); chk_ctl("ex_mem_entry", 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("ex_mem_hold", 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("ex_mem_release", 0, 0, 0);
    chk("ex_sc", int'(hif.stall_cycles), 2);
    drv(0, 1, 0, 0, 1, 0, 0, 0); chk_ctl("mem_entry", 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("mem_release", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mem_sc", int'(hif.stall_cycles), 3);
    drv(0, 0, 1, 0, 0, 0, 0, 0); chk_ctl("invalid_no_stall", 0, 0, 0);
    drv(0, 1, 1, 0, 0, 0, 0, 0); chk_ctl("br_entry", 1, 1, 0);
    chk("fwd_const_a", int'(hif.fwd_sel_a), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("br_in_stall", 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_2nd", 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_done", 0, 0, 0);
    chk("br_sc", int'(hif.stall_cycles), 4);
    chk("fwd_const_b", int'(hif.fwd_sel_b), 0);
`endif

    // Branch taken while already flushing re-enters FLUSH.
    drv(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("br_run", 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("br_reflush", 0, 1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_tail", 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_end", 0, 0, 0);

    // Reset in the middle of a stall.
    drv(0, 1, 1, 0, 0, 0, 1, 0); chk_ctl("stall_pre_rst", 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0); chk_ctl("rst_in_stall", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("rst_stall_after", 0, 0, 0);
    chk("rst_stall_sc", int'(hif.stall_cycles), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("stall_aborted", 0, 0, 0);
    chk("stall_aborted_sc", int'(hif.stall_cycles), 0);

    // Reset in the middle of a flush.
    drv(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("flush_pre_rst", 0, 1, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0); chk_ctl("rst_in_flush", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_aborted", 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("flush_aborted2", 0, 0, 0);

`ifndef FORWARD_EN
    // Continuous EX hazard stalls every cycle; counter must saturate.
    drv(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (70000) @(negedge clk);
    #1;
    chk("sat_pc_stall", int'(hif.pc_stall), 1);
    chk("sat_sc", int'(hif.stall_cycles), 16'hFFFF);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_hold_sc", int'(hif.stall_cycles), 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
